// File: rtl/cadr_sram_nxm.sv
// N-word x M-bit synchronous single-port RAM with registered read port and a
// clear sequencer that fills every word with INIT_VAL. Build option: CADR_SRAM_PARITY_EN.
module cadr_sram_nxm #(
    parameter int                ADDR_W   = 10,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce_n,
    input  logic              we_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] di,
    input  logic              init_req,
    input  logic              par_inv,
    output logic [DATA_W-1:0] dout,     // read data; "do" is a reserved word
    output logic              rd_valid,
    output logic              busy,
    output logic              par_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);
`ifdef CADR_SRAM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    // Handshake: user access (ce_n=0) is taken on the rising edge only while
    // busy=0; a read returns dout one cycle later, qualified by rd_valid.

    typedef enum logic {S_INIT, S_RUN} state_t;

    // Sequencer state kept in one struct so checkers can bind to seq.state / seq.cnt.
    typedef struct packed {
        state_t          state;
        logic [ADDR_W:0] cnt;
    } seq_t;

    seq_t seq;

    logic [WORD_W-1:0] ram [DEPTH];
    logic [WORD_W-1:0] init_word;
    logic [WORD_W-1:0] user_word;
    logic [WORD_W-1:0] rd_word;
    logic [WORD_W-1:0] wr_word;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en;
    logic              rd_bad;
    logic              user_rd;

`ifdef CADR_SRAM_PARITY_EN
    assign init_word = {^INIT_VAL, INIT_VAL};
    assign user_word = {(^di) ^ par_inv, di};
    assign rd_bad    = ^rd_word;
`else
    assign init_word = INIT_VAL;
    assign user_word = di;
    // No parity storage here, so par_inv cannot influence anything.
    assign rd_bad    = par_inv & 1'b0;
`endif

    assign rd_word = ram[addr];
    assign user_rd = (seq.state == S_RUN) && !ce_n && we_n;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = addr;
        wr_word = user_word;
        if (seq.state == S_INIT) begin
            wr_en   = 1'b1;
            wr_addr = seq.cnt[ADDR_W-1:0];
            wr_word = init_word;
        end else if (!ce_n && !we_n) begin
            wr_en = 1'b1;
        end
    end

    // While reset is held cnt sits at 0, so ram[0] may be refilled with
    // INIT_VAL; the clear that follows release writes it anyway.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[wr_addr] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seq.state <= S_INIT;
            seq.cnt   <= '0;
            busy      <= 1'b1;
            dout      <= '0;
            rd_valid  <= 1'b0;
            par_err   <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            par_err  <= 1'b0;
            case (seq.state)
                S_INIT: begin
                    seq.cnt <= seq.cnt + 1'b1;
                    if (seq.cnt == LAST) begin
                        seq.state <= S_RUN;
                        busy      <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (user_rd) begin
                        dout     <= rd_word[DATA_W-1:0];
                        rd_valid <= 1'b1;
                        par_err  <= rd_bad;
                    end
                    // An access in the request cycle is still served above.
                    if (init_req) begin
                        seq.state <= S_INIT;
                        seq.cnt   <= '0;
                        busy      <= 1'b1;
                    end
                end
                default: begin
                    seq.state <= S_INIT;
                    seq.cnt   <= '0;
                    busy      <= 1'b1;
                end
            endcase
        end
    end

endmodule
